// File: rtl/pipe_sop_pkg.sv
// Shared widths, mode encodings and stage control record for the sum-of-products engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_sop_pkg;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_ACC    = 1'b1;

  // Ceiling log2; clog2(1) = 0 so a single pair adds no tree growth bits.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned prod_w(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned tree_w(input int unsigned dw, input int unsigned npairs);
    return prod_w(dw) + clog2(npairs);
  endfunction

  function automatic int unsigned out_w(input int unsigned dw, input int unsigned npairs,
                                        input int unsigned acc_len);
    return tree_w(dw, npairs) + clog2(acc_len);
  endfunction

  // Control half of every stage record; each stage pairs it with its own data width.
  typedef struct packed {
    logic vld;
    logic mode;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_sop_engine_sop_adder_tree.sv
// Combinational unsigned reduction of NPAIRS products into one sum.
// Latency: 0 cycles (purely combinational, registered by the caller).
// Backpressure: none; the caller decides when the result is captured.
module sop_adder_tree
  import pipe_sop_pkg::*;
#(
  parameter int unsigned NPAIRS = 4,
  parameter int unsigned PW     = 16,
  localparam int unsigned TW    = PW + clog2(NPAIRS)
) (
  input  logic [NPAIRS*PW-1:0] prods,
  output logic [TW-1:0]        sum
);

  // Each product is widened to the full tree width first, so no partial sum can wrap.
  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < NPAIRS; k++) begin
      sum = sum + TW'(prods[k*PW +: PW]);
    end
  end

endmodule

// File: rtl/pipe_sop_engine.sv
// Sum of NPAIRS unsigned products per transaction, optionally accumulated over ACC_LEN transactions.
// Latency: 3 registered stages; a transaction accepted in cycle c shows on dout in cycle c+3 when unstalled.
// Backpressure: dout_busy holds S3; stalls ripple back stage by stage to din_busy, nothing is ever dropped.
module pipe_sop_engine
  import pipe_sop_pkg::*;
#(
  parameter int unsigned NPAIRS  = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned II      = 1,
  parameter int unsigned ACC_LEN = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 din_vld,
  output logic                                 din_busy,
  input  logic [2*NPAIRS*DW-1:0]               din_data,
  input  logic                                 din_mode,
  output logic                                 dout_vld,
  input  logic                                 dout_busy,
  output logic [out_w(DW,NPAIRS,ACC_LEN)-1:0]  dout_data,
  output logic                                 dout_last
);

  localparam int unsigned PW = prod_w(DW);
  localparam int unsigned TW = tree_w(DW, NPAIRS);
  localparam int unsigned OW = out_w(DW, NPAIRS, ACC_LEN);
  localparam int unsigned CW = clog2(ACC_LEN);

  typedef struct packed {
    stage_ctl_t            ctl;
    logic [NPAIRS*PW-1:0]  prods;
  } s1_rec_t;

  typedef struct packed {
    stage_ctl_t  ctl;
    logic [TW-1:0] sum;
  } s2_rec_t;

  logic [1:0]          rst_sync;
  logic                rst_n_i;
  s1_rec_t             s1;
  s2_rec_t             s2;
  logic [3:0]          ii_cnt;
  logic [CW-1:0]       in_cnt;
  logic                frame_mode;
  logic [CW-1:0]       acc_cnt;
  logic [OW-1:0]       acc;
  logic [NPAIRS*PW-1:0] prods_c;
  logic [TW-1:0]       tree_sum;
  logic [OW-1:0]       acc_sum;
  logic                acc_last;
  logic                eff_mode;
  logic                s3_adv;
  logic                s2_ld;
  logic                s1_ld;
  logic                accept;

  // Reset asserts immediately but releases only after two clean edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  // A stage loads whenever it is empty or its occupant is moving on.
  assign s3_adv   = !dout_vld || !dout_busy;
  assign s2_ld    = !s2.ctl.vld || s3_adv;
  assign s1_ld    = !s1.ctl.vld || s2_ld;
  assign din_busy = (ii_cnt != 4'd0) || !s1_ld;
  assign accept   = din_vld && !din_busy;

  // Mode is only sampled from din_mode at a frame boundary; mid-frame the latched mode wins.
  assign eff_mode = (in_cnt == '0) ? din_mode : frame_mode;

  // Full-width products, operands widened before multiplying.
  always_comb begin
    prods_c = '0;
    for (int unsigned k = 0; k < NPAIRS; k++) begin
      prods_c[k*PW +: PW] = PW'(din_data[2*k*DW +: DW]) * PW'(din_data[(2*k+1)*DW +: DW]);
    end
  end

  sop_adder_tree #(
    .NPAIRS (NPAIRS),
    .PW     (PW)
  ) u_tree (
    .prods (s1.prods),
    .sum   (tree_sum)
  );

  assign acc_sum  = acc + OW'(s2.sum);
  assign acc_last = (acc_cnt == CW'(ACC_LEN - 1));

  // Initiation-interval gap and input-side frame tracking (ACC_LEN is a power of 2, so wrap is free).
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ii_cnt     <= 4'd0;
      in_cnt     <= '0;
      frame_mode <= MODE_SINGLE;
    end else begin
      if (accept)              ii_cnt <= 4'(II - 1);
      else if (ii_cnt != 4'd0) ii_cnt <= ii_cnt - 4'd1;
      if (accept) begin
        if (in_cnt == '0)        frame_mode <= din_mode;
        if (eff_mode == MODE_ACC) in_cnt    <= in_cnt + CW'(1);
      end
    end
  end

  // S1 captures products; S2 captures the reduced sum.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (s1_ld) begin
        s1.ctl.vld  <= accept;
        s1.ctl.mode <= eff_mode;
        s1.prods    <= prods_c;
      end
      if (s2_ld) begin
        s2.ctl <= s1.ctl;
        s2.sum <= tree_sum;
      end
    end
  end

  // S3: present single results directly, absorb accumulate values until the frame's last one.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout_vld  <= 1'b0;
      dout_data <= '0;
      dout_last <= 1'b0;
      acc       <= '0;
      acc_cnt   <= '0;
    end else if (s3_adv) begin
      if (s2.ctl.vld && s2.ctl.mode == MODE_SINGLE) begin
        dout_vld  <= 1'b1;
        dout_data <= OW'(s2.sum);
        dout_last <= 1'b1;
      end else if (s2.ctl.vld && acc_last) begin
        dout_vld  <= 1'b1;
        dout_data <= acc_sum;
        dout_last <= 1'b1;
        acc       <= '0;
        acc_cnt   <= '0;
      end else if (s2.ctl.vld) begin
        dout_vld  <= 1'b0;
        acc       <= acc_sum;
        acc_cnt   <= acc_cnt + CW'(1);
      end else begin
        dout_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sop_engine.sv
module tb_pipe_sop_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        din_vld = 1'b0;
  logic        din_busy;
  logic [63:0] din_data = '0;
  logic        din_mode = 1'b0;
  logic        dout_vld;
  logic        dout_busy = 1'b0;
  logic [19:0] dout_data;
  logic        dout_last;

  logic        d3_din_vld = 1'b0;
  logic        d3_din_busy;
  logic [63:0] d3_din_data = '0;
  logic        d3_din_mode = 1'b0;
  logic        d3_dout_vld;
  logic        d3_dout_busy = 1'b0;
  logic [19:0] d3_dout_data;
  logic        d3_dout_last;

  int total = 0;
  int bad   = 0;

  logic [20:0] q[$];
  logic [20:0] q3[$];

  localparam logic [63:0] SEQ = 64'h0807060504030201;
  int exp_tab[9] = '{4, 16, 36, 64, 100, 144, 196, 256, 324};

  always #5 clk = ~clk;

  pipe_sop_engine #(.NPAIRS(4), .DW(8), .II(1), .ACC_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .din_vld(din_vld), .din_busy(din_busy), .din_data(din_data), .din_mode(din_mode),
    .dout_vld(dout_vld), .dout_busy(dout_busy), .dout_data(dout_data), .dout_last(dout_last)
  );

  pipe_sop_engine #(.NPAIRS(4), .DW(8), .II(3), .ACC_LEN(4)) dut3 (
    .clk(clk), .rst(rst),
    .din_vld(d3_din_vld), .din_busy(d3_din_busy), .din_data(d3_din_data), .din_mode(d3_din_mode),
    .dout_vld(d3_dout_vld), .dout_busy(d3_dout_busy), .dout_data(d3_dout_data), .dout_last(d3_dout_last)
  );

  // Record every completed output transfer.
  always @(posedge clk) begin
    if (dout_vld && !dout_busy)       q.push_back({dout_last, dout_data});
    if (d3_dout_vld && !d3_dout_busy) q3.push_back({d3_dout_last, d3_dout_data});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] vec(input int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {8{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Present one transaction on the II=1 engine until it transfers (bounded).
  task automatic send(input logic [63:0] data, input logic mode);
    bit done;
    done     = 1'b0;
    din_data = data;
    din_mode = mode;
    din_vld  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (!din_busy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: got busy for 50 cycles, want an accept");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_cycles(2);
    total++; if (dout_vld !== 1'b0)     begin bad++; $display("FAIL reset_dout_vld: got %b want 0", dout_vld); end
    total++; if (dout_data !== 20'd0)   begin bad++; $display("FAIL reset_dout_data: got %0h want 0", dout_data); end
    total++; if (dout_last !== 1'b0)    begin bad++; $display("FAIL reset_dout_last: got %b want 0", dout_last); end
    total++; if (din_busy !== 1'b0)     begin bad++; $display("FAIL reset_din_busy: got %b want 0", din_busy); end
    total++; if (d3_din_busy !== 1'b0)  begin bad++; $display("FAIL reset_d3_din_busy: got %b want 0", d3_din_busy); end
    rst = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_single();
    q.delete();
    din_data = SEQ; din_mode = 1'b0; din_vld = 1'b1;
    #1;
    total++; if (din_busy !== 1'b0) begin bad++; $display("FAIL single_accept: got busy=%b want 0", din_busy); end
    step();
    din_vld = 1'b0;
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL single_cyc1: got vld=%b want 0", dout_vld); end
    step();
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL single_cyc2: got vld=%b want 0", dout_vld); end
    step();
    total++; if (dout_vld !== 1'b1)     begin bad++; $display("FAIL single_cyc3_vld: got %b want 1", dout_vld); end
    total++; if (dout_data !== 20'd100) begin bad++; $display("FAIL single_data: got %0d want 100", dout_data); end
    total++; if (dout_last !== 1'b1)    begin bad++; $display("FAIL single_last: got %b want 1", dout_last); end
    step();
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL single_cyc4: got vld=%b want 0", dout_vld); end
  endtask

  task automatic test_ii3_stream();
    int n;
    bit exp_b;
    q3.delete();
    n = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      d3_din_vld  = 1'b1;
      d3_din_data = vec(n);
      d3_din_mode = 1'b0;
      #1;
      exp_b = (c % 3) != 0;
      total++;
      if (d3_din_busy !== exp_b) begin
        bad++; $display("FAIL ii3_busy_c%0d: got %b want %b", c, d3_din_busy, exp_b);
      end
      if (!d3_din_busy) n++;
      @(posedge clk);
      #1;
    end
    d3_din_vld = 1'b0;
    total++; if (n !== 9) begin bad++; $display("FAIL ii3_accepts: got %0d want 9", n); end
    wait_cycles(8);
    total++; if (q3.size() !== 9) begin bad++; $display("FAIL ii3_count: got %0d want 9", q3.size()); end
    for (int i = 0; i < 9 && i < q3.size(); i++) begin
      total++;
      if (q3[i] !== {1'b1, 20'(exp_tab[i])}) begin
        bad++; $display("FAIL ii3_result%0d: got %0h want %0h", i, q3[i], {1'b1, 20'(exp_tab[i])});
      end
    end
  endtask

  task automatic test_max_values();
    q.delete();
    send({64{1'b1}}, 1'b0);
    wait_cycles(5);
    total++; if (q.size() !== 1) begin bad++; $display("FAIL max_single_count: got %0d want 1", q.size()); end
    total++; if (q.size() > 0 && q[0] !== {1'b1, 20'h3F804}) begin
      bad++; $display("FAIL max_single_data: got %0h want %0h", q[0], {1'b1, 20'h3F804});
    end
    q.delete();
    for (int i = 0; i < 3; i++) send({64{1'b1}}, 1'b1);
    wait_cycles(4);
    total++; if (q.size() !== 0) begin bad++; $display("FAIL max_acc_intermediate: got %0d outputs want 0", q.size()); end
    send({64{1'b1}}, 1'b1);
    wait_cycles(5);
    total++; if (q.size() !== 1) begin bad++; $display("FAIL max_acc_count: got %0d want 1", q.size()); end
    total++; if (q.size() > 0 && q[0] !== {1'b1, 20'hFE010}) begin
      bad++; $display("FAIL max_acc_data: got %0h want %0h", q[0], {1'b1, 20'hFE010});
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit saw_busy;
    q.delete();
    n = 0;
    saw_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      dout_busy = (c < 10);
      din_mode  = 1'b0;
      din_vld   = (n < 8);
      din_data  = vec(n);
      #1;
      if (din_busy) saw_busy = 1'b1;
      if (c >= 3 && c < 10) begin
        total++;
        if (dout_vld !== 1'b1 || dout_data !== 20'(exp_tab[0])) begin
          bad++; $display("FAIL bp_hold_c%0d: got vld=%b data=%0d want vld=1 data=%0d", c, dout_vld, dout_data, exp_tab[0]);
        end
      end
      if (c == 9) begin
        total++;
        if (n !== 3) begin bad++; $display("FAIL bp_accepts_in_stall: got %0d want 3", n); end
      end
      if (din_vld && !din_busy) n++;
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    dout_busy = 1'b0;
    wait_cycles(5);
    total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL bp_din_busy: got never busy want busy"); end
    total++; if (q.size() !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      total++;
      if (q[i] !== {1'b1, 20'(exp_tab[i])}) begin
        bad++; $display("FAIL bp_result%0d: got %0h want %0h", i, q[i], {1'b1, 20'(exp_tab[i])});
      end
    end
  endtask

  task automatic test_mode_change();
    q.delete();
    send(SEQ, 1'b1);
    send(vec(0), 1'b0);
    send(vec(1), 1'b0);
    wait_cycles(5);
    total++; if (q.size() !== 0) begin bad++; $display("FAIL modechg_midframe: got %0d outputs want 0", q.size()); end
    send(vec(2), 1'b1);
    wait_cycles(5);
    total++; if (q.size() !== 1) begin bad++; $display("FAIL modechg_frame_count: got %0d want 1", q.size()); end
    total++; if (q.size() > 0 && q[0] !== {1'b1, 20'd156}) begin
      bad++; $display("FAIL modechg_frame_data: got %0h want %0h", q[0], {1'b1, 20'd156});
    end
    send(vec(3), 1'b0);
    wait_cycles(5);
    total++; if (q.size() !== 2) begin bad++; $display("FAIL modechg_next_count: got %0d want 2", q.size()); end
    total++; if (q.size() > 1 && q[1] !== {1'b1, 20'd64}) begin
      bad++; $display("FAIL modechg_next_data: got %0h want %0h", q[1], {1'b1, 20'd64});
    end
  endtask

  task automatic test_reset_midop();
    q.delete();
    send(vec(0), 1'b1);
    send(vec(0), 1'b1);
    wait_cycles(4);
    send(vec(1), 1'b1);
    send(vec(1), 1'b1);
    send(vec(1), 1'b1);
    rst = 1'b0;
    #1;
    total++; if (dout_vld !== 1'b0)   begin bad++; $display("FAIL rstmid_dout_vld: got %b want 0", dout_vld); end
    total++; if (dout_data !== 20'd0) begin bad++; $display("FAIL rstmid_dout_data: got %0h want 0", dout_data); end
    total++; if (dout_last !== 1'b0)  begin bad++; $display("FAIL rstmid_dout_last: got %b want 0", dout_last); end
    total++; if (din_busy !== 1'b0)   begin bad++; $display("FAIL rstmid_din_busy: got %b want 0", din_busy); end
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(4);
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rstmid_stale: got %0d outputs want 0", q.size()); end
    send(SEQ, 1'b0);
    wait_cycles(5);
    total++; if (q.size() !== 1) begin bad++; $display("FAIL rstmid_after_count: got %0d want 1", q.size()); end
    total++; if (q.size() > 0 && q[0] !== {1'b1, 20'd100}) begin
      bad++; $display("FAIL rstmid_after_data: got %0h want %0h", q[0], {1'b1, 20'd100});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ii3_stream();
    test_max_values();
    test_backpressure();
    test_mode_change();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
